// File: rtl/rom_toggle_arbiter.sv
// Purpose: shares one toggle-handshake ROM/SDRAM read port among NUM_CH fetch
//          clients; fixed priority (ch0 highest) with aging so a client that
//          keeps losing is promoted after STARVE_LIMIT lost arbitrations.
// Latency: mem_req toggles 1 clk after a request becomes pending; ch_ack and
//          ch_data update on the edge that sees mem_ack==mem_req.
// Backpressure: one transaction in flight; clients stay pending (req^ack) until
//          served, and nothing issues while the memory side's ack mismatches req.
//
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   ch_addr          packed per-channel addresses, channel i at [i*ADDR_W +: ADDR_W]
//   ch_req, ch_ack   per-channel toggle request / acknowledge
//   ch_data          data of the most recently completed transaction
//   mem_addr, mem_req, mem_ack, mem_data   toggle-handshake memory port
//   busy             high while a memory transaction is outstanding
//   grant_ch         channel being (or last) served
module rom_toggle_arbiter #(
  parameter int NUM_CH       = 4,
  parameter int ADDR_W       = 21,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8,
  localparam int CH_W        = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH-1:0]        ch_req,
  output logic [NUM_CH-1:0]        ch_ack,
  output logic [DATA_W-1:0]        ch_data,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_req,
  input  logic                     mem_ack,
  input  logic [DATA_W-1:0]        mem_data,
  output logic                     busy,
  output logic [CH_W-1:0]          grant_ch
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [NUM_CH-1:0]   pending;
  logic [3:0]          age [NUM_CH];
  logic                sel_req;

  logic [CH_W-1:0]     win;
  logic [CH_W-1:0]     win_plain;
  logic [CH_W-1:0]     win_starved;
  logic                have_starved;
  logic [ADDR_W-1:0]   win_addr;
  logic                win_req;
  logic                mem_idle;
  logic                issue;
  logic                done;

  assign pending  = ch_req ^ ch_ack;
  assign mem_idle = (mem_ack == mem_req);

  // Winner selection: scanning from the top down leaves the lowest index in
  // each candidate, so a starved channel only beats lower-index pending ones.
  always_comb begin
    win_plain    = '0;
    win_starved  = '0;
    have_starved = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending[i]) begin
        win_plain = CH_W'(i);
        if (age[i] >= 4'(STARVE_LIMIT)) begin
          win_starved  = CH_W'(i);
          have_starved = 1'b1;
        end
      end
    end
    win = have_starved ? win_starved : win_plain;
  end

  // Address and request level of the winner, muxed with constant slices.
  always_comb begin
    win_addr = '0;
    win_req  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (CH_W'(i) == win) begin
        win_addr = ch_addr[i*ADDR_W +: ADDR_W];
        win_req  = ch_req[i];
      end
    end
  end

  // Next-state logic. A mismatched mem_ack in IDLE means the memory side is
  // still finishing something we no longer own (e.g. it came out of reset
  // late), so issuing is held off until it settles.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if ((|pending) && mem_idle) begin
          issue   = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_idle) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath. ch_ack is restored from the latched request level rather than
  // toggled, so a client that re-toggles while pending stays pending and is
  // served again later.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req  <= 1'b0;
      mem_addr <= '0;
      ch_ack   <= '0;
      ch_data  <= '0;
      busy     <= 1'b0;
      grant_ch <= '0;
      sel_req  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        age[i] <= '0;
      end
    end else begin
      if (issue) begin
        mem_addr <= win_addr;
        mem_req  <= ~mem_req;
        sel_req  <= win_req;
        grant_ch <= win;
        busy     <= 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
          if (CH_W'(i) == win) begin
            age[i] <= '0;
          end else if (pending[i]) begin
            age[i] <= (age[i] == 4'hF) ? age[i] : age[i] + 4'd1;
          end else begin
            age[i] <= '0;
          end
        end
      end
      if (done) begin
        ch_data          <= mem_data;
        ch_ack[grant_ch] <= sel_req;
        busy             <= 1'b0;
      end
    end
  end

endmodule
